// File: rtl/gcd_job_sequencer.sv
// gcd_job_sequencer: Avalon-MM front end that queues operand pairs, feeds them
// one at a time to the GCD engine and collects results in a FIFO for the CPU.
// Jobs with a zero operand are resolved locally (the engine cannot finish them).
module gcd_job_sequencer #(
  parameter int DEPTH = 4,
  parameter int CW    = 3
) (
  input  logic        csi_clk,
  input  logic        rsi_reset,
  input  logic [1:0]  avs_address,
  input  logic        avs_write,
  input  logic [31:0] avs_writedata,
  input  logic        avs_read,
  output logic [31:0] avs_readdata,
  output logic        gcd_start,
  output logic [31:0] gcd_a,
  output logic [31:0] gcd_b,
  input  logic        gcd_done,
  input  logic [31:0] gcd_result,
  output logic        irq
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_WRITE = 2'd3
  } state_e;

  // Storage and state
  logic [63:0]   job_mem_q [DEPTH];
  logic [31:0]   res_mem_q [DEPTH];
  logic [AW-1:0] job_wp_q, job_rp_q, res_wp_q, res_rp_q;
  logic [CW-1:0] job_cnt_q, job_cnt_d, res_cnt_q, res_cnt_d;
  logic [31:0]   a_stage_q;
  state_e        state_q, state_d;
  logic [31:0]   gcd_a_q, gcd_a_d, gcd_b_q, gcd_b_d, res_val_q, res_val_d;
  logic          start_q;
  logic          ovf_q, ovf_d, unf_q, unf_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          irq_q;

  // Bus decode and FIFO handshakes
  logic        wr_a_s, wr_job_s, wr_clr_s, rd_res_s;
  logic        job_full_s, job_empty_s, res_empty_s;
  logic        job_push_s, job_pop_s, res_push_s, res_pop_s;
  logic [31:0] job_head_a_s, job_head_b_s, res_head_s, status_s;

  assign wr_a_s   = avs_write && (avs_address == 2'd0);
  assign wr_job_s = avs_write && (avs_address == 2'd1);
  assign wr_clr_s = avs_write && (avs_address == 2'd3) && avs_writedata[0];
  assign rd_res_s = avs_read  && (avs_address == 2'd2);

  assign job_full_s   = (job_cnt_q == FULL_CNT);
  assign job_empty_s  = (job_cnt_q == {CW{1'b0}});
  assign res_empty_s  = (res_cnt_q == {CW{1'b0}});
  assign job_head_a_s = job_mem_q[job_rp_q][63:32];
  assign job_head_b_s = job_mem_q[job_rp_q][31:0];
  assign res_head_s   = res_mem_q[res_rp_q];

  // A pop in the same cycle frees a slot, so a push to a full FIFO still lands
  assign job_push_s = wr_job_s && (!job_full_s || job_pop_s);
  assign res_pop_s  = rd_res_s && !res_empty_s;

  // Next-state logic: dispatch, issue, wait for engine, write result
  always_comb begin
    state_d    = state_q;
    gcd_a_d    = gcd_a_q;
    gcd_b_d    = gcd_b_q;
    res_val_d  = res_val_q;
    job_pop_s  = 1'b0;
    res_push_s = 1'b0;
    case (state_q)
      S_IDLE: begin
        // done must be low: the engine keeps done high across a late start
        if (!job_empty_s && (res_cnt_q != FULL_CNT) && !gcd_done) begin
          job_pop_s = 1'b1;
          if ((job_head_a_s == 32'd0) || (job_head_b_s == 32'd0)) begin
            res_val_d = job_head_a_s | job_head_b_s;
            state_d   = S_WRITE;
          end else begin
            gcd_a_d = job_head_a_s;
            gcd_b_d = job_head_b_s;
            state_d = S_ISSUE;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        if (gcd_done) begin
          res_val_d = gcd_result;
          state_d   = S_WRITE;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_WRITE: begin
        res_push_s = 1'b1;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FIFO occupancy next values
  always_comb begin
    job_cnt_d = job_cnt_q;
    res_cnt_d = res_cnt_q;
    case ({job_push_s, job_pop_s})
      2'b10:   job_cnt_d = job_cnt_q + CNT_ONE;
      2'b01:   job_cnt_d = job_cnt_q - CNT_ONE;
      default: job_cnt_d = job_cnt_q;
    endcase
    case ({res_push_s, res_pop_s})
      2'b10:   res_cnt_d = res_cnt_q + CNT_ONE;
      2'b01:   res_cnt_d = res_cnt_q - CNT_ONE;
      default: res_cnt_d = res_cnt_q;
    endcase
  end

  // Status word, sticky flags and read data
  always_comb begin
    status_s           = 32'd0;
    status_s[CW-1:0]   = job_cnt_q;
    status_s[8 +: CW]  = res_cnt_q;
    status_s[16]       = (state_q != S_IDLE);
    status_s[17]       = ovf_q;
    status_s[18]       = unf_q;

    if (wr_job_s && job_full_s && !job_pop_s) begin
      ovf_d = 1'b1;
    end else if (wr_clr_s) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end

    if (rd_res_s && res_empty_s) begin
      unf_d = 1'b1;
    end else if (wr_clr_s) begin
      unf_d = 1'b0;
    end else begin
      unf_d = unf_q;
    end

    rdata_d = rdata_q;
    if (avs_read) begin
      case (avs_address)
        2'd2:    rdata_d = res_empty_s ? 32'd0 : res_head_s;
        2'd3:    rdata_d = status_s;
        default: rdata_d = 32'd0;
      endcase
    end else begin
      rdata_d = rdata_q;
    end
  end

  // FIFO entry storage (contents are don't-care while the pointers say empty)
  always_ff @(posedge csi_clk) begin
    if (job_push_s) job_mem_q[job_wp_q] <= {a_stage_q, avs_writedata};
    if (res_push_s) res_mem_q[res_wp_q] <= res_val_q;
  end

  // FIFO pointers, counts and the A staging register
  always_ff @(posedge csi_clk or posedge rsi_reset) begin
    if (rsi_reset) begin
      job_wp_q  <= {AW{1'b0}};
      job_rp_q  <= {AW{1'b0}};
      res_wp_q  <= {AW{1'b0}};
      res_rp_q  <= {AW{1'b0}};
      job_cnt_q <= {CW{1'b0}};
      res_cnt_q <= {CW{1'b0}};
      a_stage_q <= 32'd0;
    end else begin
      if (job_push_s) job_wp_q <= job_wp_q + PTR_ONE;
      if (job_pop_s)  job_rp_q <= job_rp_q + PTR_ONE;
      if (res_push_s) res_wp_q <= res_wp_q + PTR_ONE;
      if (res_pop_s)  res_rp_q <= res_rp_q + PTR_ONE;
      job_cnt_q <= job_cnt_d;
      res_cnt_q <= res_cnt_d;
      if (wr_a_s) a_stage_q <= avs_writedata;
    end
  end

  // Sequencer state, engine operands, captured result and registered outputs
  always_ff @(posedge csi_clk or posedge rsi_reset) begin
    if (rsi_reset) begin
      state_q   <= S_IDLE;
      gcd_a_q   <= 32'd0;
      gcd_b_q   <= 32'd0;
      res_val_q <= 32'd0;
      start_q   <= 1'b0;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
      rdata_q   <= 32'd0;
      irq_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      gcd_a_q   <= gcd_a_d;
      gcd_b_q   <= gcd_b_d;
      res_val_q <= res_val_d;
      start_q   <= (state_d == S_ISSUE);
      ovf_q     <= ovf_d;
      unf_q     <= unf_d;
      rdata_q   <= rdata_d;
      irq_q     <= (res_cnt_d != {CW{1'b0}});
    end
  end

  assign gcd_start    = start_q;
  assign gcd_a        = gcd_a_q;
  assign gcd_b        = gcd_b_q;
  assign avs_readdata = rdata_q;
  assign irq          = irq_q;

endmodule

// File: doc/gcd_job_sequencer.md
Name: gcd_job_sequencer

Overview:
- Upstream/downstream wrapper for the GCD custom-instruction engine.
- The CPU queues operand pairs over an Avalon-MM slave, and the block feeds them one at a time to the engine with a one-cycle start pulse.
- Results are collected into a result FIFO that the CPU drains; the CPU never has to stall on a single computation.
- Zero-operand jobs are resolved locally, because the engine cannot terminate on them.

Parameters:
- DEPTH, 4, entries in each of the job FIFO and the result FIFO; must be a power of 2, ≥2.
- CW, 3, width of the count fields; equals log2(DEPTH)+1.

Ports:
- csi_clk  in  1  clock.
- rsi_reset  in  1  asynchronous, active-high reset.
- avs_address  in  2  register select.
- avs_write  in  1  register write strobe.
- avs_writedata  in  32  write data.
- avs_read  in  1  register read strobe.
- avs_readdata  out  32  read data; registered, read latency 1.
- gcd_start  out  1  one-cycle start pulse to the engine.
- gcd_a  out  32  operand A to the engine.
- gcd_b  out  32  operand B to the engine.
- gcd_done  in  1  engine completion flag.
- gcd_result  in  32  engine result; valid while gcd_done=1.
- irq  out  1  level interrupt; high while the result FIFO is non-empty.

Behaviour:
- Reset (async, active-high): both FIFOs empty, sticky flags 0, FSM=IDLE, gcd_start=0, gcd_a=gcd_b=0, avs_readdata=0, irq=0.
- Register map, addr 0, write: load the A staging register.
- Addr 1, write: push the pair {A staging, writedata} into the job FIFO.
  - If the job FIFO is full, the pair is dropped and sticky OVF=1.
- Addr 2, read: pop the result FIFO; avs_readdata = head on the next cycle.
  - If the result FIFO is empty, return 0 and set sticky UNF=1.
- Addr 3, read: status word.
  - [CW-1:0] = job count.
  - [8+CW-1:8] = result count.
  - [16] = busy (FSM ≠ IDLE).
  - [17] = OVF.
  - [18] = UNF.
  - Other bits 0.
- Addr 3, write with bit0=1: clear OVF and UNF.
- Reads of addr 0 and addr 1 return 0.
- Simultaneous push and pop on either FIFO in the same cycle: both take effect, count unchanged.
  - A push to a full FIFO is accepted in the same cycle as a pop.
- FSM states and transitions:
  - IDLE → (job FIFO non-empty AND result FIFO count + 0 < DEPTH AND gcd_done=0): pop the job.
    - If A=0 or B=0: result = A|B, go to WRITE (gcd(0,0)=0; engine never started).
    - Otherwise: drive gcd_a/gcd_b, go to ISSUE.
  - ISSUE: gcd_start=1 for exactly this cycle; gcd_a/gcd_b stay held. Go to WAIT.
  - WAIT: when gcd_done=1, capture gcd_result and go to WRITE. No timeout.
  - WRITE: push the captured result into the result FIFO (space was guaranteed at dispatch). Go to IDLE.
- The gcd_done=0 requirement in IDLE is mandatory: the engine holds done high across a start issued the cycle after completion, which would return a stale result.
- Minimum pipeline overhead for a non-zero job is 3 cycles beyond engine compute time (IDLE, ISSUE, WRITE); a zero-operand job takes 2 cycles (IDLE, WRITE).
- gcd_a/gcd_b hold their last issued values outside ISSUE/WAIT.
- gcd_done is ignored in every state except WAIT.
- Reset mid-job: FSM returns to IDLE and queued jobs and results are lost.
  - The engine may still be running; the next ISSUE restarts it, since start has priority in the engine.
  - The gcd_done=0 guard prevents capturing its leftover completion.
- Results leave the result FIFO in job submission order, including locally resolved zero jobs.
- irq = result FIFO non-empty, registered.

Test Plan:
- Single job: write A=48 (addr 0), B=18 (addr 1).
  - Exactly one gcd_start pulse with gcd_a=48, gcd_b=18.
  - Engine model returns 6; irq rises; read addr 2 → 6.
  - Status then shows counts 0 and busy=0.
- Queue 4 jobs back-to-back: (48,18), (17,5), (100,75), (7,7).
  - Four start pulses, each issued only after gcd_done has returned low.
  - Results read in order: 6, 1, 25, 7.
- Zero operands: jobs (0,9), (12,0), (0,0).
  - No gcd_start pulse for any of them.
  - Results 9, 12, 0, each ready within 2 cycles of dispatch.
- Overflow/underflow with DEPTH=4, engine held busy: push 5 pairs → status job count=4, OVF=1.
  - Read addr 2 while empty → 0 and UNF=1.
  - Write addr 3 = 1 → OVF=UNF=0.
- Backpressure: fill the result FIFO (4 results unread), queue a 5th job.
  - No dispatch until one result is read; then the job issues and its result appears as the 4th entry.
- Reset asserted during WAIT of job (1000000,2), engine still running: after release all counts are 0 and irq=0.
  - A new job (21,14) returns 7, not the stale engine result.
